i2c_target: RTL and testbench
=============================

# i2c_target

I2C target (slave) endpoint with a 128×8 register file. It is the responder to the team's I2C initiator and connects to the same SCL/SDA wires. It detects START/STOP, matches its 7-bit address and ACKs it, accepts a register pointer followed by write data, and returns read data MSB-first. It holds the bus low only through an open-drain enable and never drives SCL; clock stretching is not supported.

## Interface
- `DEV_ADDR`, default 7'h50: 7-bit target address.
- `SYNC_STAGES`, default 2: synchronizer depth on `scl_i` and `sda_i`; minimum 2.
- `clk` in 1: system clock; must run at 16× or more the SCL frequency.
- `rst` in 1: reset, synchronous, active-high; clock `clk`.
- `scl_i` in 1: raw SCL level from the pad.
- `sda_i` in 1: raw SDA level from the pad. This is the wired-AND of the initiator and `~sda_oe`.
- `sda_oe` out 1: when 1, the pad pulls SDA low. When 0, SDA is released.
- `wr_strobe` out 1: one-cycle pulse when a data byte is committed to memory.
- `wr_addr` out 7: register index of the last committed write.
- `wr_data` out 8: value of the last committed write.
- `busy` out 1: high from an address-matched START until STOP, mismatch, or NACK termination.
- `dbg_addr` in 7: backdoor read index.
- `dbg_data` out 8: `mem[dbg_addr]`, registered, 1-cycle latency.

## Operation
- **Line conditioning:** SCL and SDA pass through `SYNC_STAGES` flops, then a one-flop edge detect.
- **Event definitions:**
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Data is sampled on SCL rise.
  - `sda_oe` changes only on a detected SCL fall, or on START/STOP.
- **Byte order:** all bytes are MSB first. The address byte is {addr[6:0], R/W}; R/W=0 means write.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- **IDLE:** wait for START, then enter ADDR with bit count 0.
- **ADDR:** shift 8 bits.
  - On the SCL fall after bit 8: if addr == `DEV_ADDR`, assert `sda_oe`, set `busy`, and enter ADDR_ACK.
  - On mismatch: enter IDLE; `sda_oe` stays 0.
- **ADDR_ACK:** on the next SCL fall, exit as follows.
  - Write: release SDA and enter PTR.
  - Read: load `shreg = mem[ptr]`, drive `sda_oe = ~shreg[7]`, and enter RDATA.
- **PTR:** 8 bits received; `ptr <= byte[6:0]`, and bit 7 is ignored. ACK cycle in PTR_ACK, then WDATA.
- **WDATA:** 8 bits received.
  - On the 8th SCL rise: `mem[ptr] <= byte`; pulse `wr_strobe` with `wr_addr=ptr` and `wr_data=byte`.
  - `ptr <= ptr+1` mod 128; 7'h7F wraps to 7'h00.
  - ACK in WDATA_ACK, then WDATA again.
- **RDATA:** shift the byte out on successive SCL falls. On the fall after bit 8, release SDA and enter RDATA_ACK.
- **RDATA_ACK:** sample the initiator on SCL rise; `ptr <= ptr+1` on both ACK and NACK.
  - ACK (0): on the next fall, load `mem[ptr]`, drive its MSB, and enter RDATA.
  - NACK (1): enter IDLE and clear `busy`.
- **STOP, any state:** enter IDLE, `sda_oe <= 0`, clear `busy`. A partial byte is discarded; `ptr` and memory are retained.
- **Repeated START, any state:** `sda_oe <= 0`, `busy <= 0`, enter ADDR. A repeated-START read uses the `ptr` set by the preceding write phase.
- **Arbitration:** a START, STOP, and SCL edge detected in the same cycle is treated as START or STOP only (priority STOP > START > SCL edge).
- **Reset:**
  - State IDLE; `ptr=0`.
  - `sda_oe`, `wr_strobe`, `busy` = 0.
  - `wr_addr`, `wr_data`, `dbg_data` = 0.
  - All mem = 8'h00.
  - Reset mid-transfer releases SDA on the next cycle, and the target ignores the bus until the next START.

## Timing
- Pad-to-internal event latency: `SYNC_STAGES`+1 cycles (3 at default).
- An SCL fall at the pad produces an `sda_oe` change `SYNC_STAGES`+2 cycles later, so SDA hold after SCL fall is ≥4 clk.
- `wr_strobe`: high exactly 1 cycle, `SYNC_STAGES`+2 cycles after the 8th data-bit SCL rise at the pad.
- A STOP or START detection deasserts `sda_oe` in the following cycle.
- `dbg_data` reflects a write committed in cycle N from cycle N+2.

## Structure
- `i2c_pkg` holds the `i2c_target_state_t` enum, `I2C_ADDR_W=7`, `I2C_DATA_W=8`, and `I2C_MEM_DEPTH=128`.
- Sub-module `i2c_line_sync` contains the synchronizer and edge detector for SCL+SDA. It outputs `scl_rise`, `scl_fall`, `start_det`, `stop_det`, and the synced levels.
- The memory is inferred inside `i2c_target`.

## Test plan
- **Write with auto-increment:** START, 0xA0, ptr 0x10, data 0x3C, 0xA5, STOP.
  - ACKs on all 4 bytes.
  - `wr_strobe` twice with (0x10,0x3C) and (0x11,0xA5).
  - `dbg_data` reads those values back.
- **Combined read:** preload 0x10=0x3C and 0x11=0xA5. START, 0xA0, 0x10, repeated START, 0xA1, read 2 bytes with ACK then NACK, STOP.
  - Initiator samples 0x3C then 0xA5.
  - `busy` drops after the NACK.
- **Address mismatch:** START, 0x42.
  - `sda_oe` is never 1, `busy` stays 0, and no `wr_strobe`.
  - A following valid transaction to 0xA0 succeeds.
- **Wrap-around:** write ptr 0x7F with data 0x11, 0x22.
  - mem[0x7F]=0x11 and mem[0x00]=0x22.
  - `wr_addr` sequence is 0x7F then 0x00.
- **Abort:** STOP after 4 bits of a data byte.
  - No `wr_strobe`, `sda_oe`=0, IDLE.
  - A next read from ptr returns the unmodified byte.
- **Reset mid-read while driving 0:** assert `rst` for 1 cycle.
  - `sda_oe`=0 the next cycle.
  - The remaining SCL pulses are ignored until a new START.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and sizes for the I2C target endpoint.
// No logic: state encoding plus address/data/memory dimensions.
package i2c_pkg;

    localparam int I2C_ADDR_W    = 7;
    localparam int I2C_DATA_W    = 8;
    localparam int I2C_MEM_DEPTH = 128;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK
    } i2c_target_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer + edge/START/STOP detect; events registered, SYNC_STAGES+1 cycles after the pad.
// No backpressure: one-cycle event pulses, levels aligned with the events.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_pipe;
    logic [SYNC_STAGES-1:0] sda_pipe;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_pipe[SYNC_STAGES-1];
    assign sda_s = sda_pipe[SYNC_STAGES-1];

    // The chain keeps tracking the pads through reset so that no phantom
    // START/STOP is manufactured when reset releases mid-transfer.
    always_ff @(posedge clk) begin
        scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl_i};
        sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda_i};
        scl      <= scl_s;
        sda      <= sda_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_rise  <= scl_s & ~scl;
            scl_fall  <= ~scl_s & scl;
            start_det <= scl_s & scl & sda & ~sda_s;
            stop_det  <= scl_s & scl & ~sda & sda_s;
        end
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target with 128x8 register file; sda_oe moves SYNC_STAGES+2 clk after a pad SCL fall.
// Never stretches SCL; the initiator paces every byte.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] DEV_ADDR    = 7'h50,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic                  wr_strobe,
    output logic [I2C_ADDR_W-1:0] wr_addr,
    output logic [I2C_DATA_W-1:0] wr_data,
    output logic                  busy,
    input  logic [I2C_ADDR_W-1:0] dbg_addr,
    output logic [I2C_DATA_W-1:0] dbg_data
);

    logic scl_lvl, sda_lvl, scl_rise, scl_fall, start_det, stop_det;
    logic sda_bit;

    i2c_target_state_t     state;
    logic [3:0]            cnt;
    logic [I2C_DATA_W-1:0] shreg;
    logic [I2C_ADDR_W-1:0] ptr;
    logic                  rw;
    logic [I2C_DATA_W-1:0] rx_byte;
    logic [I2C_DATA_W-1:0] mem [I2C_MEM_DEPTH];

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl       (scl_lvl),
        .sda       (sda_lvl),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign sda_bit = sda_lvl & scl_lvl;
    assign rx_byte = {shreg[6:0], sda_bit};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            ptr       <= '0;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            for (int i = 0; i < I2C_MEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start_det) begin
                state  <= ADDR;
                cnt    <= '0;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ADDR, PTR, WDATA: begin
                        if (scl_rise && cnt < 4'd8) begin
                            shreg <= rx_byte;
                            cnt   <= cnt + 4'd1;
                            if (state == WDATA && cnt == 4'd7) begin
                                mem[ptr]  <= rx_byte;
                                wr_strobe <= 1'b1;
                                wr_addr   <= ptr;
                                wr_data   <= rx_byte;
                                ptr       <= ptr + 7'd1;
                            end
                        end else if (scl_fall && cnt == 4'd8) begin
                            cnt <= '0;
                            if (state == ADDR) begin
                                if (shreg[7:1] == DEV_ADDR) begin
                                    sda_oe <= 1'b1;
                                    busy   <= 1'b1;
                                    rw     <= shreg[0];
                                    state  <= ADDR_ACK;
                                end else begin
                                    state <= IDLE;
                                end
                            end else if (state == PTR) begin
                                ptr    <= shreg[6:0];
                                sda_oe <= 1'b1;
                                state  <= PTR_ACK;
                            end else begin
                                sda_oe <= 1'b1;
                                state  <= WDATA_ACK;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                shreg  <= mem[ptr];
                                sda_oe <= ~mem[ptr][7];
                                cnt    <= 4'd1;
                                state  <= RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                cnt    <= '0;
                                state  <= PTR;
                            end
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            cnt    <= '0;
                            state  <= WDATA;
                        end
                    end
                    // cnt counts bits already placed on the line, MSB placed on entry.
                    RDATA: begin
                        if (scl_fall) begin
                            if (cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                cnt    <= '0;
                                state  <= RDATA_ACK;
                            end else begin
                                sda_oe <= ~shreg[6];
                                shreg  <= {shreg[6:0], 1'b0};
                                cnt    <= cnt + 4'd1;
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            ptr <= ptr + 7'd1;
                            if (sda_bit) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                cnt <= 4'd1;
                            end
                        end else if (scl_fall && cnt == 4'd1) begin
                            shreg  <= mem[ptr];
                            sda_oe <= ~mem[ptr][7];
                            state  <= RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) dbg_data <= '0;
        else     dbg_data <= mem[dbg_addr];
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged initiator, table vectors, directed corner cases, random traffic.
// A byte-level register-file model predicts ACKs, read data and write strobes.
module tb_i2c_target;

    localparam int         T   = 6;
    localparam logic [6:0] DEV = 7'h50;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_i;
    logic       sda_m;
    logic       sda_i;
    logic       sda_oe;
    logic       wr_strobe;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic [6:0] dbg_addr;
    logic [7:0] dbg_data;

    assign sda_i = sda_m & ~sda_oe;

    i2c_target #(.DEV_ADDR(DEV), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_oe    (sda_oe),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        logic [7:0] addr_byte;
        logic [7:0] ptr_byte;
        logic [7:0] data;
        logic       exp_ack;
        int         exp_strobes;
    } vec_t;

    wr_t        wr_q[$];
    bit         oe_seen;
    bit         busy_seen;
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] mdl_mem [128];
    logic [6:0] mdl_ptr;

    always @(negedge clk) begin
        if (wr_strobe) wr_q.push_back({wr_addr, wr_data});
        if (sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_cyc(input logic b, output logic r);
        tick(T); sda_m = b;
        tick(T); scl_i = 1'b1;
        tick(T); r = sda_i;
        tick(T); scl_i = 1'b0;
    endtask

    task automatic do_start();
        if (!scl_i) begin
            tick(T); sda_m = 1'b1;
            tick(T); scl_i = 1'b1;
        end
        tick(T); sda_m = 1'b0;
        tick(T); scl_i = 1'b0;
    endtask

    task automatic do_stop();
        tick(T); sda_m = 1'b0;
        tick(T); scl_i = 1'b1;
        tick(T); sda_m = 1'b1;
        tick(T);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_cyc(b[i], r);
        bit_cyc(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_cyc(1'b1, r);
            d[i] = r;
        end
        bit_cyc(nack, r);
    endtask

    task automatic dbg_check(input logic [6:0] a, input string tag);
        dbg_addr = a;
        tick(2);
        check(tag, 32'(dbg_data), 32'(mdl_mem[a]));
    endtask

    task automatic i2c_write(input logic [6:0] p, input logic [7:0] d [4], input int n, input string tag);
        logic       ack;
        int         nacks;
        logic [6:0] a;
        nacks = 0;
        wr_q.delete();
        do_start();
        write_byte({DEV, 1'b0}, ack); if (!ack) nacks++;
        write_byte({1'b0, p}, ack);   if (!ack) nacks++;
        for (int i = 0; i < n; i++) begin
            write_byte(d[i], ack);
            if (!ack) nacks++;
        end
        do_stop();
        check({tag, " nacks"}, 32'(nacks), 32'd0);
        check({tag, " strobes"}, 32'(wr_q.size()), 32'(n));
        a = p;
        for (int i = 0; i < n; i++) begin
            mdl_mem[a] = d[i];
            if (i < wr_q.size()) begin
                check({tag, " wr_addr"}, 32'(wr_q[i].a), 32'(a));
                check({tag, " wr_data"}, 32'(wr_q[i].d), 32'(d[i]));
            end
            a = a + 7'd1;
        end
        mdl_ptr = a;
    endtask

    task automatic i2c_read(input logic set_ptr, input logic [6:0] p, input int n, input string tag);
        logic       ack;
        logic [7:0] d;
        logic [6:0] a;
        do_start();
        if (set_ptr) begin
            write_byte({DEV, 1'b0}, ack);
            check({tag, " wr addr ack"}, 32'(ack), 32'd1);
            write_byte({1'b0, p}, ack);
            check({tag, " ptr ack"}, 32'(ack), 32'd1);
            mdl_ptr = p;
            do_start();
        end
        write_byte({DEV, 1'b1}, ack);
        check({tag, " rd addr ack"}, 32'(ack), 32'd1);
        check({tag, " busy during"}, 32'(busy), 32'd1);
        a = mdl_ptr;
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, d);
            check({tag, " rdata"}, 32'(d), 32'(mdl_mem[a]));
            a = a + 7'd1;
        end
        mdl_ptr = a;
        check({tag, " busy after nack"}, 32'(busy), 32'd0);
        do_stop();
    endtask

    initial begin
        vec_t       vt [6];
        logic [7:0] buf4 [4];
        logic       ack;
        logic       r;
        logic [6:0] p;
        int         n;
        int         kind;

        vt[0] = '{8'hA0, 8'h05, 8'h5A, 1'b1, 1};
        vt[1] = '{8'h42, 8'h06, 8'hFF, 1'b0, 0};
        vt[2] = '{8'hA2, 8'h05, 8'h00, 1'b0, 0};
        vt[3] = '{8'h20, 8'h05, 8'h11, 1'b0, 0};
        vt[4] = '{8'hA0, 8'h7F, 8'h80, 1'b1, 1};
        vt[5] = '{8'hA0, 8'h85, 8'hC3, 1'b1, 1};

        for (int i = 0; i < 128; i++) mdl_mem[i] = 8'h00;
        mdl_ptr  = 7'h00;
        rst      = 1'b1;
        scl_i    = 1'b1;
        sda_m    = 1'b1;
        dbg_addr = 7'h00;
        tick(10);
        rst = 1'b0;
        tick(1);

        check("reset sda_oe", 32'(sda_oe), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset wr_strobe", 32'(wr_strobe), 32'd0);
        check("reset wr_addr", 32'(wr_addr), 32'd0);
        check("reset wr_data", 32'(wr_data), 32'd0);
        check("reset dbg_data", 32'(dbg_data), 32'd0);

        for (int v = 0; v < 6; v++) begin
            oe_seen   = 1'b0;
            busy_seen = 1'b0;
            wr_q.delete();
            do_start();
            write_byte(vt[v].addr_byte, ack);
            check($sformatf("vec%0d addr ack", v), 32'(ack), 32'(vt[v].exp_ack));
            write_byte(vt[v].ptr_byte, ack);
            write_byte(vt[v].data, ack);
            do_stop();
            check($sformatf("vec%0d oe_seen", v), 32'(oe_seen), 32'(vt[v].exp_ack));
            check($sformatf("vec%0d busy_seen", v), 32'(busy_seen), 32'(vt[v].exp_ack));
            check($sformatf("vec%0d strobes", v), 32'(wr_q.size()), 32'(vt[v].exp_strobes));
            if (vt[v].exp_strobes == 1) begin
                mdl_mem[vt[v].ptr_byte[6:0]] = vt[v].data;
                mdl_ptr = vt[v].ptr_byte[6:0] + 7'd1;
                if (wr_q.size() > 0) begin
                    check($sformatf("vec%0d wr_addr", v), 32'(wr_q[0].a), 32'(vt[v].ptr_byte[6:0]));
                    check($sformatf("vec%0d wr_data", v), 32'(wr_q[0].d), 32'(vt[v].data));
                end
            end
            dbg_check(vt[v].ptr_byte[6:0], $sformatf("vec%0d dbg", v));
        end

        buf4 = '{8'h3C, 8'hA5, 8'h00, 8'h00};
        i2c_write(7'h10, buf4, 2, "autoinc");
        dbg_check(7'h10, "autoinc dbg 10");
        dbg_check(7'h11, "autoinc dbg 11");

        i2c_read(1'b1, 7'h10, 2, "combined");

        oe_seen   = 1'b0;
        busy_seen = 1'b0;
        wr_q.delete();
        do_start();
        write_byte(8'h42, ack);
        do_stop();
        check("mismatch ack", 32'(ack), 32'd0);
        check("mismatch oe_seen", 32'(oe_seen), 32'd0);
        check("mismatch busy_seen", 32'(busy_seen), 32'd0);
        check("mismatch strobes", 32'(wr_q.size()), 32'd0);
        buf4 = '{8'h99, 8'h00, 8'h00, 8'h00};
        i2c_write(7'h20, buf4, 1, "after mismatch");

        buf4 = '{8'h11, 8'h22, 8'h00, 8'h00};
        i2c_write(7'h7F, buf4, 2, "wrap");
        dbg_check(7'h7F, "wrap dbg 7f");
        dbg_check(7'h00, "wrap dbg 00");

        wr_q.delete();
        do_start();
        write_byte({DEV, 1'b0}, ack);
        check("abort addr ack", 32'(ack), 32'd1);
        write_byte(8'h11, ack);
        check("abort ptr ack", 32'(ack), 32'd1);
        for (int i = 0; i < 4; i++) bit_cyc(1'b1, r);
        do_stop();
        tick(2);
        check("abort strobes", 32'(wr_q.size()), 32'd0);
        check("abort sda_oe", 32'(sda_oe), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        mdl_ptr = 7'h11;
        i2c_read(1'b0, 7'h00, 1, "abort readback");

        buf4 = '{8'h12, 8'h00, 8'h00, 8'h00};
        i2c_write(7'h30, buf4, 1, "pre reset");
        do_start();
        write_byte({DEV, 1'b0}, ack);
        write_byte(8'h30, ack);
        do_start();
        write_byte({DEV, 1'b1}, ack);
        check("midrd addr ack", 32'(ack), 32'd1);
        tick(T);
        check("midrd driving 0", 32'(sda_oe), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrd sda_oe after rst", 32'(sda_oe), 32'd0);
        for (int i = 0; i < 128; i++) mdl_mem[i] = 8'h00;
        mdl_ptr   = 7'h00;
        oe_seen   = 1'b0;
        busy_seen = 1'b0;
        wr_q.delete();
        for (int i = 0; i < 9; i++) bit_cyc(1'b1, r);
        check("midrd oe_seen", 32'(oe_seen), 32'd0);
        check("midrd busy_seen", 32'(busy_seen), 32'd0);
        check("midrd strobes", 32'(wr_q.size()), 32'd0);
        do_stop();
        i2c_read(1'b1, 7'h30, 1, "post reset");
        dbg_check(7'h30, "post reset dbg");

        for (int k = 0; k < 16; k++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                p = 7'($urandom_range(0, 127));
                n = $urandom_range(1, 3);
                for (int j = 0; j < 4; j++) buf4[j] = 8'($urandom);
                i2c_write(p, buf4, n, "rnd wr");
                dbg_check(p, "rnd dbg");
            end else if (kind == 1) begin
                i2c_read(1'b1, 7'($urandom_range(0, 127)), $urandom_range(1, 3), "rnd rd");
            end else begin
                i2c_read(1'b0, 7'h00, $urandom_range(1, 2), "rnd cur");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
